// File: rtl/ntt_sel_gen.sv
// ntt_sel_gen: bank-select sequencer for the 4-BFU butterfly-output crossbar.
//
// Steps through LOGN stages of N/8 butterfly groups (N = 2^LOGN). Each issue
// cycle it emits eight registered 3-bit select codes
//   sel_a_k = ((k + s) mod 8) ^ {1'b0, c[1:0]}
// where s is the stage and c is the group. Consecutive stages are separated by
// DRAIN idle cycles, and a one-cycle done pulse follows the last issue.
//
// Parameters:
//   LOGN   log2 transform size (3..12)
//   DRAIN  idle cycles between stages (0..15)
// Ports:
//   clk, rst          clock, async active-high reset
//   start             single-cycle request; honoured only in IDLE
//   inv               (NTT_SEL_GEN_INTT_EN builds only) reverse stage order
//   busy              high from the first issue cycle through the done cycle
//   valid             select codes are meaningful this cycle
//   stage, grp        current stage / group (0 outside issue cycles)
//   sel_a_0..sel_a_7  crossbar select codes {bf[1:0], upper}
//   done              one-cycle completion pulse
//
// Optional feature macro: NTT_SEL_GEN_INTT_EN adds the inv port for
// inverse (descending-stage) transforms.

// One crossbar lane: registers its select code from the next-cycle stage and
// group so that the code lines up with valid/stage/grp.
module ntt_sel_lane #(
  parameter logic [2:0] K = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [2:0] s3,
  input  logic [1:0] c2,
  output logic [2:0] sel
);

  // 3-bit add wraps naturally, giving the mod-8 rotation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel <= 3'd0;
    else     sel <= run ? ((K + s3) ^ {1'b0, c2}) : 3'd0;
  end

endmodule

module ntt_sel_gen #(
  parameter  int LOGN  = 8,
  parameter  int DRAIN = 7,
  localparam int SW    = (LOGN > 2) ? $clog2(LOGN) : 1,
  localparam int GW    = (LOGN > 3) ? LOGN - 3 : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef NTT_SEL_GEN_INTT_EN
  input  logic          inv,
`endif
  output logic          busy,
  output logic          valid,
  output logic [SW-1:0] stage,
  output logic [GW-1:0] grp,
  output logic [2:0]    sel_a_0,
  output logic [2:0]    sel_a_1,
  output logic [2:0]    sel_a_2,
  output logic [2:0]    sel_a_3,
  output logic [2:0]    sel_a_4,
  output logic [2:0]    sel_a_5,
  output logic [2:0]    sel_a_6,
  output logic [2:0]    sel_a_7,
  output logic          done
);

  localparam int             NLANE  = 8;
  localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);
  // For LOGN=3 there is a single group per stage, so the last group is 0.
  localparam logic [GW-1:0] C_LAST = GW'((1 << (LOGN - 3)) - 1);
  localparam logic [3:0]    D_LOAD = 4'(DRAIN - 1);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t        st, st_n;
  logic [SW-1:0] s_q, s_n, s_step;
  logic [GW-1:0] c_q, c_n;
  logic [3:0]    d_q, d_n;
  logic          inv_q, inv_n, inv_in;
  logic          s_end, run_n;
  logic [2:0]    s3;
  logic [1:0]    c2;
  logic [NLANE-1:0][2:0] sel_q;

`ifdef NTT_SEL_GEN_INTT_EN
  assign inv_in = inv;
`else
  assign inv_in = 1'b0;
`endif

  // Direction is latched at start so the whole transform runs one way.
  assign s_end  = inv_q ? (s_q == '0) : (s_q == S_LAST);
  assign s_step = inv_q ? (s_q - 1'b1) : (s_q + 1'b1);

  always_comb begin
    st_n  = st;
    s_n   = s_q;
    c_n   = c_q;
    d_n   = d_q;
    inv_n = inv_q;
    unique case (st)
      IDLE: if (start) begin
        st_n  = RUN;
        inv_n = inv_in;
        s_n   = inv_in ? S_LAST : '0;
        c_n   = '0;
      end
      RUN: begin
        if (c_q == C_LAST) begin
          c_n = '0;
          if (s_end)           st_n = DONE;
          else if (DRAIN == 0) s_n  = s_step;   // stages run back to back
          else begin
            st_n = GAP;
            d_n  = D_LOAD;
          end
        end else begin
          c_n = c_q + 1'b1;
        end
      end
      GAP: begin
        if (d_q == '0) begin
          st_n = RUN;
          s_n  = s_step;
        end else begin
          d_n = d_q - 1'b1;
        end
      end
      DONE:    st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  assign run_n = (st_n == RUN);

  // Outputs are registered from next-state values so they change on the same
  // edge as the state, giving one cycle from start to the first issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= IDLE;
      s_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      inv_q <= 1'b0;
      busy  <= 1'b0;
      valid <= 1'b0;
      stage <= '0;
      grp   <= '0;
      done  <= 1'b0;
    end else begin
      st    <= st_n;
      s_q   <= s_n;
      c_q   <= c_n;
      d_q   <= d_n;
      inv_q <= inv_n;
      busy  <= (st_n != IDLE);
      valid <= run_n;
      stage <= run_n ? s_n : '0;
      grp   <= run_n ? c_n : '0;
      done  <= (st_n == DONE);
    end
  end

  // Narrow stage/group into the fixed widths the select rule needs.
  generate
    if (SW >= 3) begin : g_s3
      assign s3 = s_n[2:0];
    end else begin : g_s3
      assign s3 = {{(3 - SW){1'b0}}, s_n};
    end
    if (GW >= 2) begin : g_c2
      assign c2 = c_n[1:0];
    end else begin : g_c2
      assign c2 = {1'b0, c_n};
    end
  endgenerate

  generate
    for (genvar k = 0; k < NLANE; k++) begin : g_lane
      ntt_sel_lane #(.K(3'(k))) u_lane (
        .clk (clk),
        .rst (rst),
        .run (run_n),
        .s3  (s3),
        .c2  (c2),
        .sel (sel_q[k])
      );
    end
  endgenerate

  assign sel_a_0 = sel_q[0];
  assign sel_a_1 = sel_q[1];
  assign sel_a_2 = sel_q[2];
  assign sel_a_3 = sel_q[3];
  assign sel_a_4 = sel_q[4];
  assign sel_a_5 = sel_q[5];
  assign sel_a_6 = sel_q[6];
  assign sel_a_7 = sel_q[7];

endmodule

// File: tb/tb_ntt_sel_gen.sv
// Scoreboard bench for ntt_sel_gen: a default instance (LOGN=8, DRAIN=7) and
// a small one (LOGN=3, DRAIN=0). Accepted starts push a cycle-by-cycle
// expected trace; per-instance monitors pop and compare every cycle.
module tb_ntt_sel_gen;

  typedef struct {
    logic v;
    int   s;
    int   c;
    logic d;
    logic b;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start8, start3;
`ifdef NTT_SEL_GEN_INTT_EN
  logic inv8, inv3;
`endif

  logic       busy8, v8, done8;
  logic [2:0] stage8;
  logic [4:0] grp8;
  logic [7:0][2:0] sv8;
  logic       busy3, v3, done3;
  logic [1:0] stage3;
  logic [0:0] grp3;
  logic [7:0][2:0] sv3;

  exp_t q8[$];
  exp_t q3[$];
  exp_t idle_e = '{v:1'b0, s:0, c:0, d:1'b0, b:1'b0};
  int   n_chk = 0;
  int   n_fail = 0;
  int   vcnt[2] = '{0, 0};

  always #5 clk = ~clk;

  ntt_sel_gen #(.LOGN(8), .DRAIN(7)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8),
`ifdef NTT_SEL_GEN_INTT_EN
    .inv(inv8),
`endif
    .busy(busy8), .valid(v8), .stage(stage8), .grp(grp8),
    .sel_a_0(sv8[0]), .sel_a_1(sv8[1]), .sel_a_2(sv8[2]), .sel_a_3(sv8[3]),
    .sel_a_4(sv8[4]), .sel_a_5(sv8[5]), .sel_a_6(sv8[6]), .sel_a_7(sv8[7]),
    .done(done8)
  );

  ntt_sel_gen #(.LOGN(3), .DRAIN(0)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3),
`ifdef NTT_SEL_GEN_INTT_EN
    .inv(inv3),
`endif
    .busy(busy3), .valid(v3), .stage(stage3), .grp(grp3),
    .sel_a_0(sv3[0]), .sel_a_1(sv3[1]), .sel_a_2(sv3[2]), .sel_a_3(sv3[3]),
    .sel_a_4(sv3[4]), .sel_a_5(sv3[5]), .sel_a_6(sv3[6]), .sel_a_7(sv3[7]),
    .done(done3)
  );

  // ---------------- reference model ----------------
  task automatic qpush(input int which, input exp_t e);
    if (which == 0) q8.push_back(e);
    else            q3.push_back(e);
  endtask

  function automatic int qsize(input int which);
    return (which == 0) ? q8.size() : q3.size();
  endfunction

  // Trace of one transform, starting with the (idle) cycle start is driven in.
  task automatic push_run(input int which, input int logn, input int drain, input bit inv);
    int   ng = (1 << logn) / 8;
    exp_t e;
    qpush(which, idle_e);
    for (int i = 0; i < logn; i++) begin
      for (int c = 0; c < ng; c++) begin
        e = '{v:1'b1, s:(inv ? logn - 1 - i : i), c:c, d:1'b0, b:1'b1};
        qpush(which, e);
      end
      if (i < logn - 1)
        for (int d = 0; d < drain; d++) begin
          e = '{v:1'b0, s:0, c:0, d:1'b0, b:1'b1};
          qpush(which, e);
        end
    end
    e = '{v:1'b0, s:0, c:0, d:1'b1, b:1'b1};
    qpush(which, e);
  endtask

  // ---------------- checking ----------------
  task automatic check(input int which, input exp_t e, input logic v, input int st,
                       input int gr, input logic [7:0][2:0] sv, input logic d, input logic b);
    logic [7:0][2:0] es;
    bit ok, dup;
    int vtot;
    for (int k = 0; k < 8; k++)
      es[k] = e.v ? 3'(((k + e.s) % 8) ^ (e.c % 4)) : 3'd0;
    ok = (v === e.v) && (st == e.s) && (gr == e.c) && (d === e.d) && (b === e.b) && (sv === es);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cycle_dut%0d t=%0t got v=%0b s=%0d c=%0d sel=%h done=%0b busy=%0b want v=%0b s=%0d c=%0d sel=%h done=%0b busy=%0b",
               which, $time, v, st, gr, sv, d, b, e.v, e.s, e.c, es, e.d, e.b);
    end
    if (v) begin
      vcnt[which]++;
      dup = 1'b0;
      for (int i = 0; i < 8; i++)
        for (int j = i + 1; j < 8; j++)
          if (sv[i] == sv[j]) dup = 1'b1;
      n_chk++;
      if (dup) begin
        n_fail++;
        $display("FAIL distinct_dut%0d t=%0t got sel=%h want 8 distinct codes", which, $time, sv);
      end
    end
    if (d) begin
      vtot = (which == 0) ? 8 * 32 : 3;
      n_chk++;
      if (vcnt[which] != vtot) begin
        n_fail++;
        $display("FAIL vcount_dut%0d got %0d want %0d", which, vcnt[which], vtot);
      end
      vcnt[which] = 0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q8.size() > 0) e = q8.pop_front();
      else               e = idle_e;
      check(0, e, v8, int'(stage8), int'(grp8), sv8, done8, busy8);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q3.size() > 0) e = q3.pop_front();
      else               e = idle_e;
      check(1, e, v3, int'(stage3), int'(grp3), sv3, done3, busy3);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_zero();
    n_chk++;
    if ({busy8, v8, done8, stage8, grp8, sv8, busy3, v3, done3, stage3, grp3, sv3} != '0) begin
      n_fail++;
      $display("FAIL reset_zero got v8=%0b busy8=%0b sel8=%h s8=%0d c8=%0d v3=%0b busy3=%0b want all 0",
               v8, busy8, sv8, stage8, grp8, v3, busy3);
    end
  endtask

  // Start is accepted only if the cycle it is driven in is idle, i.e. the
  // model has nothing left outstanding for that instance.
  task automatic pulse(input int which, input bit iv);
    if (which == 0) begin
      start8 = 1'b1;
`ifdef NTT_SEL_GEN_INTT_EN
      inv8 = iv;
`endif
      if (q8.size() == 0) push_run(0, 8, 7, iv);
    end else begin
      start3 = 1'b1;
`ifdef NTT_SEL_GEN_INTT_EN
      inv3 = iv;
`endif
      if (q3.size() == 0) push_run(1, 3, 0, iv);
    end
    cyc();
    start8 = 1'b0;
    start3 = 1'b0;
  endtask

  // Run out the expected trace, sprinkling random starts that must be ignored.
  task automatic wait_run(input int which);
    int n = 0;
    while (qsize(which) != 0 && n < 4000) begin
      if ($urandom_range(0, 15) == 0) begin
        if (which == 0) start8 = 1'b1;
        else            start3 = 1'b1;
      end
      cyc();
      start8 = 1'b0;
      start3 = 1'b0;
      n++;
    end
    if (qsize(which) != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout_dut%0d got %0d entries pending want 0", which, qsize(which));
      if (which == 0) q8.delete();
      else            q3.delete();
    end
  endtask

  function automatic bit rand_inv();
`ifdef NTT_SEL_GEN_INTT_EN
    return bit'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    rst = 1'b1;
    start8 = 1'b0;
    start3 = 1'b0;
`ifdef NTT_SEL_GEN_INTT_EN
    inv8 = 1'b0;
    inv3 = 1'b0;
`endif
    repeat (2) cyc();
    rst_zero();
    rst = 1'b0;
    repeat (20) cyc();

    // Abort mid-run at cycle 50: outputs clear at once, no done, clean restart.
    pulse(0, 1'b0);
    repeat (49) cyc();
    #1 rst = 1'b1;
    #1 rst_zero();
    q8.delete();
    q3.delete();
    vcnt = '{0, 0};
    cyc();
    rst = 1'b0;
    repeat (2) cyc();

    // Full default run; starts at 100 and 306 ignored, 307 accepted.
    pulse(0, 1'b0);
    repeat (99) cyc();
    pulse(0, 1'b0);
    repeat (205) cyc();
    pulse(0, 1'b0);
    pulse(0, 1'b0);
    wait_run(0);

`ifdef NTT_SEL_GEN_INTT_EN
    pulse(0, 1'b1);
    wait_run(0);
`endif

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 12)) cyc();
      pulse(0, rand_inv());
      wait_run(0);
    end

    // Small instance: continuous stages, back-to-back restarts.
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 1) repeat ($urandom_range(0, 5)) cyc();
      pulse(1, rand_inv());
      wait_run(1);
    end

    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
